// File: rtl/part4_pkg.sv
// Shared types and widths for the Part4 sweep controller and its accumulator.
package part4_pkg;

    localparam int unsigned INP_W = 6;
    localparam int unsigned OUT_W = 5;
    localparam int unsigned SUM_W = 11;
    localparam int unsigned CNT_W = 7;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    typedef struct packed {
        logic [SUM_W-1:0] sum;
        logic [OUT_W-1:0] min;
        logic [OUT_W-1:0] max;
        logic [CNT_W-1:0] count;
    } acc_res_t;

    // min starts at all-ones so the first sample always replaces it
    localparam acc_res_t ACC_RESET = '{
        sum:   SUM_W'(0),
        min:   {OUT_W{1'b1}},
        max:   OUT_W'(0),
        count: CNT_W'(0)
    };

    // Next sweep point, wrapping 63 -> 0
    function automatic logic [INP_W-1:0] next_inp(input logic [INP_W-1:0] inp);
        return INP_W'(inp + INP_W'(1));
    endfunction

endpackage

// File: rtl/part4_sweep_acc.sv
// Sweep result registers: running sum, min, max and sample count.
module part4_sweep_acc
    import part4_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    input  logic [OUT_W-1:0] sample,
    output acc_res_t         res
);

    acc_res_t res_next;

    // Clear wins over accumulate; the controller never asserts both together
    always_comb begin
        res_next = res;
        if (clr) begin
            res_next = ACC_RESET;
        end else if (en) begin
            res_next.sum   = res.sum + SUM_W'(sample);
            res_next.count = res.count + CNT_W'(1);
            if (sample < res.min) begin
                res_next.min = sample;
            end
            if (sample > res.max) begin
                res_next.max = sample;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            res <= ACC_RESET;
        end else begin
            res <= res_next;
        end
    end

endmodule

// File: rtl/part4_sweep_ctrl.sv
// Steps a Part4 input across [firstVal..lastVal] (wrapping), waits LATENCY
// cycles per point, and accumulates sum/min/max/count of the Part4 output.
module part4_sweep_ctrl
    import part4_pkg::*;
#(
    parameter int unsigned LATENCY = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [INP_W-1:0] firstVal,
    input  logic [INP_W-1:0] lastVal,
    input  logic             abort,
    input  logic             doneAck,
    output logic [INP_W-1:0] dutInp,
    input  logic [OUT_W-1:0] dutOut,
    output logic             busy,
    output logic             done,
    output logic [SUM_W-1:0] sumOut,
    output logic [OUT_W-1:0] minOut,
    output logic [OUT_W-1:0] maxOut,
    output logic [CNT_W-1:0] countOut
);

    localparam int unsigned SET_W       = 2;
    localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(LATENCY - 1);

    state_t           state;
    state_t           state_next;
    logic [INP_W-1:0] last_q;
    logic [INP_W-1:0] last_next;
    logic [INP_W-1:0] inp_next;
    logic [SET_W-1:0] settle_cnt;
    logic [SET_W-1:0] settle_next;
    logic             busy_next;
    logic             done_next;
    logic             acc_clr;
    logic             acc_en;
    acc_res_t         res;

    // Next-state, datapath steering and registered-output decode
    always_comb begin
        state_next  = state;
        last_next   = last_q;
        inp_next    = dutInp;
        settle_next = settle_cnt;
        acc_clr     = 1'b0;
        acc_en      = 1'b0;

        unique case (state)
            IDLE: begin
                if (start) begin
                    last_next   = lastVal;
                    inp_next    = firstVal;
                    settle_next = SET_W'(0);
                    acc_clr     = 1'b1;
                    state_next  = SETTLE;
                end
            end
            SETTLE: begin
                if (abort) begin
                    acc_clr    = 1'b1;
                    state_next = IDLE;
                end else if (settle_cnt == SETTLE_LAST) begin
                    state_next = SAMPLE;
                end else begin
                    settle_next = settle_cnt + SET_W'(1);
                end
            end
            SAMPLE: begin
                // Abort beats completion: nothing from this point is kept
                if (abort) begin
                    acc_clr    = 1'b1;
                    state_next = IDLE;
                end else begin
                    acc_en = 1'b1;
                    if (dutInp == last_q) begin
                        state_next = DONE;
                    end else begin
                        inp_next    = next_inp(dutInp);
                        settle_next = SET_W'(0);
                        state_next  = SETTLE;
                    end
                end
            end
            DONE: begin
                if (doneAck) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        busy_next = (state_next == SETTLE) || (state_next == SAMPLE);
        done_next = (state_next == DONE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            last_q     <= INP_W'(0);
            dutInp     <= INP_W'(0);
            settle_cnt <= SET_W'(0);
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_next;
            last_q     <= last_next;
            dutInp     <= inp_next;
            settle_cnt <= settle_next;
            busy       <= busy_next;
            done       <= done_next;
        end
    end

    part4_sweep_acc u_acc (
        .clk    (clk),
        .reset  (reset),
        .clr    (acc_clr),
        .en     (acc_en),
        .sample (dutOut),
        .res    (res)
    );

    assign sumOut   = res.sum;
    assign minOut   = res.min;
    assign maxOut   = res.max;
    assign countOut = res.count;

endmodule

// File: tb/tb_part4_sweep_ctrl.sv
// Directed bench for part4_sweep_ctrl with a delayed Part4 model (out = inp[4:0]).
module tb_part4_sweep_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // LATENCY=1 instance
    logic       reset, start, abort, doneAck, busy, done;
    logic [5:0] firstVal, lastVal, dutInp;
    logic [4:0] dutOut, minOut, maxOut;
    logic [10:0] sumOut;
    logic [6:0] countOut;

    // LATENCY=3 instance
    logic       reset3, start3, abort3, ack3, busy3, done3;
    logic [5:0] first3, last3, inp3;
    logic [4:0] out3, min3, max3;
    logic [10:0] sum3;
    logic [6:0] count3;

    int checks = 0;
    int failures = 0;

    part4_sweep_ctrl #(.LATENCY(1)) dut (
        .clk(clk), .reset(reset), .start(start), .firstVal(firstVal), .lastVal(lastVal),
        .abort(abort), .doneAck(doneAck), .dutInp(dutInp), .dutOut(dutOut),
        .busy(busy), .done(done), .sumOut(sumOut), .minOut(minOut), .maxOut(maxOut),
        .countOut(countOut)
    );

    part4_sweep_ctrl #(.LATENCY(3)) dut3 (
        .clk(clk), .reset(reset3), .start(start3), .firstVal(first3), .lastVal(last3),
        .abort(abort3), .doneAck(ack3), .dutInp(inp3), .dutOut(out3),
        .busy(busy3), .done(done3), .sumOut(sum3), .minOut(min3), .maxOut(max3),
        .countOut(count3)
    );

    // Part4 models: output follows inp[4:0] after LATENCY edges
    logic [4:0] d1;
    logic [4:0] d3 [3];
    always @(posedge clk) begin
        d1    <= dutInp[4:0];
        d3[0] <= inp3[4:0];
        d3[1] <= d3[0];
        d3[2] <= d3[1];
    end
    assign dutOut = d1;
    assign out3   = d3[2];

    task automatic launch(input logic [5:0] f, input logic [5:0] l);
        @(negedge clk);
        firstVal = f;
        lastVal  = l;
        start    = 1'b1;
    endtask

    // Counts edges from the start-sampling edge (edge 0) until done is seen.
    // At edge 'inj' it pulses start/doneAck with a bogus range to prove they are ignored.
    task automatic wait_done(input int inj, output int edges, output bit timeout, output logic busy0);
        edges   = -1;
        timeout = 1'b1;
        busy0   = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk);
            edges++;
            #1;
            if (edges == 0) busy0 = busy;
            if (edges == inj) begin
                start = 1'b1; doneAck = 1'b1; firstVal = 6'd40; lastVal = 6'd41;
            end else begin
                start = 1'b0; doneAck = 1'b0;
            end
            if (done) begin
                timeout = 1'b0;
                break;
            end
        end
        start   = 1'b0;
        doneAck = 1'b0;
    endtask

    task automatic ack_done();
        @(negedge clk);
        doneAck = 1'b1;
        @(posedge clk);
        #1;
        doneAck = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; reset3 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1; reset3 = 1'b1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0d exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%0d exp=0", done); end
        checks++; if (dutInp !== 6'd0) begin failures++; $display("FAIL reset_inp got=%0d exp=0", dutInp); end
        checks++; if (sumOut !== 11'd0) begin failures++; $display("FAIL reset_sum got=%0d exp=0", sumOut); end
        checks++; if (minOut !== 5'h1F) begin failures++; $display("FAIL reset_min got=%0d exp=31", minOut); end
        checks++; if (maxOut !== 5'd0) begin failures++; $display("FAIL reset_max got=%0d exp=0", maxOut); end
        checks++; if (countOut !== 7'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", countOut); end
        checks++; if (done3 !== 1'b0 || busy3 !== 1'b0) begin failures++; $display("FAIL reset3_flags got=%0d%0d exp=00", busy3, done3); end
    endtask

    task automatic test_full_sweep();
        int e; bit to; logic b0;
        launch(6'd0, 6'd63);
        wait_done(10, e, to, b0);
        checks++; if (to) begin failures++; $display("FAIL full_timeout got=timeout exp=done"); end
        checks++; if (b0 !== 1'b1) begin failures++; $display("FAIL full_busy_edge0 got=%0d exp=1", b0); end
        checks++; if (e !== 128) begin failures++; $display("FAIL full_done_edge got=%0d exp=128", e); end
        checks++; if (countOut !== 7'd64) begin failures++; $display("FAIL full_count got=%0d exp=64", countOut); end
        checks++; if (sumOut !== 11'd992) begin failures++; $display("FAIL full_sum got=%0d exp=992", sumOut); end
        checks++; if (minOut !== 5'd0) begin failures++; $display("FAIL full_min got=%0d exp=0", minOut); end
        checks++; if (maxOut !== 5'd31) begin failures++; $display("FAIL full_max got=%0d exp=31", maxOut); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL full_busy_done got=%0d exp=0", busy); end
        checks++; if (dutInp !== 6'd63) begin failures++; $display("FAIL full_inp_hold got=%0d exp=63", dutInp); end
        ack_done();
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL full_ack got=%0d exp=0", done); end
    endtask

    task automatic test_wrap();
        int e; bit to; logic b0;
        launch(6'd62, 6'd1);
        wait_done(-5, e, to, b0);
        checks++; if (to || e !== 8) begin failures++; $display("FAIL wrap_done_edge got=%0d exp=8", e); end
        checks++; if (countOut !== 7'd4) begin failures++; $display("FAIL wrap_count got=%0d exp=4", countOut); end
        checks++; if (sumOut !== 11'd62) begin failures++; $display("FAIL wrap_sum got=%0d exp=62", sumOut); end
        checks++; if (minOut !== 5'd0) begin failures++; $display("FAIL wrap_min got=%0d exp=0", minOut); end
        checks++; if (maxOut !== 5'd31) begin failures++; $display("FAIL wrap_max got=%0d exp=31", maxOut); end
        ack_done();
    endtask

    task automatic test_single_point();
        int e; bit to; logic b0;
        launch(6'd5, 6'd5);
        wait_done(-5, e, to, b0);
        checks++; if (to || e !== 2) begin failures++; $display("FAIL single_done_edge got=%0d exp=2", e); end
        checks++; if (countOut !== 7'd1) begin failures++; $display("FAIL single_count got=%0d exp=1", countOut); end
        checks++; if (sumOut !== 11'd5) begin failures++; $display("FAIL single_sum got=%0d exp=5", sumOut); end
        checks++; if (minOut !== 5'd5 || maxOut !== 5'd5) begin failures++; $display("FAIL single_minmax got=%0d/%0d exp=5/5", minOut, maxOut); end
        ack_done();
    endtask

    task automatic test_done_hold();
        int e; bit to; logic b0;
        launch(6'd3, 6'd6);
        wait_done(-5, e, to, b0);
        checks++; if (to || e !== 8) begin failures++; $display("FAIL hold_done_edge got=%0d exp=8", e); end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            start    = (i % 2 == 0);
            firstVal = 6'd20;
            lastVal  = 6'd30;
        end
        @(negedge clk);
        start = 1'b0;
        checks++; if (done !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL hold_flags got=busy%0d_done%0d exp=busy0_done1", busy, done); end
        checks++; if (sumOut !== 11'd18 || countOut !== 7'd4) begin failures++; $display("FAIL hold_sum_count got=%0d/%0d exp=18/4", sumOut, countOut); end
        checks++; if (minOut !== 5'd3 || maxOut !== 5'd6) begin failures++; $display("FAIL hold_minmax got=%0d/%0d exp=3/6", minOut, maxOut); end
        checks++; if (dutInp !== 6'd6) begin failures++; $display("FAIL hold_inp got=%0d exp=6", dutInp); end
        ack_done();
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL hold_ack got=busy%0d_done%0d exp=busy0_done0", busy, done); end
        repeat (3) @(posedge clk);
        #1;
        checks++; if (dutInp !== 6'd6) begin failures++; $display("FAIL idle_inp_hold got=%0d exp=6", dutInp); end
    endtask

    task automatic test_abort();
        int e; bit to; logic b0; bit seen_done; bit found;
        found = 1'b0;
        launch(6'd0, 6'd63);
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            if (dutInp == 6'd10) begin found = 1'b1; break; end
        end
        checks++; if (!found) begin failures++; $display("FAIL abort_reach got=timeout exp=inp10"); end
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%0d exp=0", busy); end
        checks++; if (sumOut !== 11'd0 || countOut !== 7'd0) begin failures++; $display("FAIL abort_sum_count got=%0d/%0d exp=0/0", sumOut, countOut); end
        checks++; if (minOut !== 5'h1F || maxOut !== 5'd0) begin failures++; $display("FAIL abort_minmax got=%0d/%0d exp=31/0", minOut, maxOut); end
        seen_done = 1'b0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (done) seen_done = 1'b1;
        end
        checks++; if (seen_done) begin failures++; $display("FAIL abort_no_done got=1 exp=0"); end
        launch(6'd2, 6'd4);
        wait_done(-5, e, to, b0);
        checks++; if (to || e !== 6) begin failures++; $display("FAIL restart_done_edge got=%0d exp=6", e); end
        checks++; if (sumOut !== 11'd9 || countOut !== 7'd3) begin failures++; $display("FAIL restart_sum_count got=%0d/%0d exp=9/3", sumOut, countOut); end
        checks++; if (minOut !== 5'd2 || maxOut !== 5'd4) begin failures++; $display("FAIL restart_minmax got=%0d/%0d exp=2/4", minOut, maxOut); end
        ack_done();
    endtask

    task automatic test_abort_priority();
        bit seen_done;
        launch(6'd7, 6'd7);
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        seen_done = done;
        checks++; if (busy !== 1'b0 || countOut !== 7'd0 || sumOut !== 11'd0) begin failures++; $display("FAIL abort_prio got=busy%0d_cnt%0d_sum%0d exp=busy0_cnt0_sum0", busy, countOut, sumOut); end
        repeat (3) begin
            @(posedge clk);
            #1;
            if (done) seen_done = 1'b1;
        end
        checks++; if (seen_done) begin failures++; $display("FAIL abort_prio_done got=1 exp=0"); end
    endtask

    task automatic test_reset_mid();
        launch(6'd0, 6'd63);
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (19) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL rstmid_flags got=busy%0d_done%0d exp=busy0_done0", busy, done); end
        checks++; if (dutInp !== 6'd0) begin failures++; $display("FAIL rstmid_inp got=%0d exp=0", dutInp); end
        checks++; if (sumOut !== 11'd0 || countOut !== 7'd0) begin failures++; $display("FAIL rstmid_sum_count got=%0d/%0d exp=0/0", sumOut, countOut); end
        checks++; if (minOut !== 5'h1F || maxOut !== 5'd0) begin failures++; $display("FAIL rstmid_minmax got=%0d/%0d exp=31/0", minOut, maxOut); end
    endtask

    task automatic test_latency3();
        int e; bit to;
        e  = -1;
        to = 1'b1;
        @(negedge clk);
        first3 = 6'd0;
        last3  = 6'd7;
        start3 = 1'b1;
        for (int i = 0; i < 500; i++) begin
            @(posedge clk);
            e++;
            #1;
            start3 = 1'b0;
            if (done3) begin to = 1'b0; break; end
        end
        checks++; if (to || e !== 32) begin failures++; $display("FAIL lat3_done_edge got=%0d exp=32", e); end
        checks++; if (sum3 !== 11'd28) begin failures++; $display("FAIL lat3_sum got=%0d exp=28", sum3); end
        checks++; if (count3 !== 7'd8) begin failures++; $display("FAIL lat3_count got=%0d exp=8", count3); end
        checks++; if (min3 !== 5'd0 || max3 !== 5'd7) begin failures++; $display("FAIL lat3_minmax got=%0d/%0d exp=0/7", min3, max3); end
        @(negedge clk);
        ack3 = 1'b1;
        @(posedge clk);
        #1;
        ack3 = 1'b0;
        checks++; if (done3 !== 1'b0) begin failures++; $display("FAIL lat3_ack got=%0d exp=0", done3); end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0; doneAck = 1'b0;
        firstVal = 6'd0; lastVal = 6'd0;
        reset3 = 1'b1; start3 = 1'b0; abort3 = 1'b0; ack3 = 1'b0;
        first3 = 6'd0; last3 = 6'd0;

        test_reset();
        test_full_sweep();
        test_wrap();
        test_single_point();
        test_done_hold();
        test_abort();
        test_abort_priority();
        test_reset_mid();
        test_latency3();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/part4_sweep_ctrl.md
PART4_SWEEP_CTRL -- requirements
Module: part4_sweep_ctrl

Interface
REQ-001 SHALL have parameter LATENCY, default 1, meaning cycles from dutInp change to valid dutOut; legal range 1..4.
REQ-002 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  in  1  synchronous, active-low reset: 0 sampled on a rising clk edge resets the block.
REQ-004 SHALL have port start  in  1  single-cycle request to begin a sweep.
REQ-005 SHALL have port firstVal  in  6  first Part4 input value of the sweep.
REQ-006 SHALL have port lastVal  in  6  last Part4 input value of the sweep.
REQ-007 SHALL have port abort  in  1  terminates an active sweep.
REQ-008 SHALL have port doneAck  in  1  consumer acknowledge of results.
REQ-009 SHALL have port dutInp  out  6  drives Part4 inpBus.
REQ-010 SHALL have port dutOut  in  5  receives Part4 outBus.
REQ-011 SHALL have ports busy  out  1  and  done  out  1  for sweep active and results valid.
REQ-012 SHALL have ports sumOut  out  11, minOut  out  5, maxOut  out  5 and countOut  out  7, all sweep results.

Function
REQ-013 SHALL implement FSM states IDLE, SETTLE, SAMPLE and DONE.
REQ-014 IDLE with start=1: SHALL latch firstVal/lastVal, load dutInp=firstVal, clear results to reset values, then go to SETTLE; busy=1 from the next cycle.
REQ-015 SETTLE SHALL last exactly LATENCY cycles, then go to SAMPLE.
REQ-016 SAMPLE SHALL last 1 cycle and accumulate dutOut: sum+=dutOut (zero-extended), min/max updated, count+=1.
REQ-017 SAMPLE with dutInp==latched lastVal SHALL go to DONE; otherwise dutInp+=1 modulo 64 and go to SETTLE.
REQ-018 If lastVal<firstVal, the sweep SHALL wrap 63->0; points N=((lastVal-firstVal) mod 64)+1, range 1..64.
REQ-019 DONE: SHALL hold done=1, busy=0 and all results stable until doneAck=1, then go to IDLE.
REQ-020 Latency: done SHALL be first seen N*(LATENCY+1) rising edges after the edge that samples start.
REQ-021 start SHALL be ignored in SETTLE, SAMPLE and DONE; doneAck SHALL be ignored outside DONE.
REQ-022 abort in SETTLE or SAMPLE SHALL return to IDLE next edge, with results at reset values and done never asserted; abort has priority over SAMPLE completion.
REQ-023 dutInp SHALL hold its last value in IDLE and DONE.
REQ-024 sumOut SHALL NOT overflow: max 64*31=1984 < 2^11.
REQ-025 countOut SHALL equal N at DONE.

Reset
REQ-026 reset=0 SHALL take effect at the next rising edge from any state, including mid-sweep, and SHALL have priority over all inputs.
REQ-027 Reset values SHALL be: state IDLE, dutInp=0, busy=0, done=0, sumOut=0, minOut=5'h1F, maxOut=0, countOut=0.

Structure
REQ-028 Package part4_pkg SHALL hold the state enum and constants INP_W=6, OUT_W=5, SUM_W=11 and CNT_W=7.
REQ-029 The block SHALL contain one sub-module, part4_sweep_acc, holding the sum/min/max/count registers with clear and accumulate controls.
REQ-030 The FSM, settle counter and dutInp register SHALL reside in part4_sweep_ctrl.

Verification
Each scenario below uses a bench Part4 model with dutOut = inp[4:0], delayed by LATENCY cycles.
REQ-031 Full sweep (first=0, last=63, LATENCY=1) -> count=64, sum=992, min=0, max=31; done at edge 128.
REQ-032 Wrap sweep (first=62, last=1) -> values 62,63,0,1; count=4, sum=62, min=0, max=31.
REQ-033 Single point (first=last=5) -> count=1, sum=5, min=max=5; done at edge 2.
REQ-034 abort during point 10 of a 0..63 sweep -> busy=0 next edge, done stays 0, results at reset values; a new start then runs normally.
REQ-035 DONE held 20 cycles with start pulses and no doneAck -> results unchanged; doneAck -> IDLE next edge.
REQ-036 reset=0 mid-sweep -> all REQ-027 values next edge. Separately, LATENCY=3 with first=0, last=7 -> sum=28; done at edge 32.
